ysyx_22041207_mem_responder: RTL
================================

# ysyx_22041207_mem_responder

Responder (target) end of the memory stage's valid/ready load/store bus. It accepts one write or one read request at a time and services it from an internal byte-addressable 64-bit-word memory after a fixed latency. It then returns a write-done or read-data response through its own valid/ready handshake. In the NPC it sits where the AXI model sits, behind the memory stage, for RTL-only simulation and bring-up.

## Interface
Parameters:
- DEPTH, 4096 — memory size in 64-bit words; power of two.
- BASE, 64'h8000_0000 — byte address of word 0.
- LATENCY, 2 — cycles from request accept to response valid; ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- w_valid_i  in  1  write request valid
- w_ready_o  out  1  write request accepted when high with w_valid_i
- w_addr_i  in  64  write byte address
- w_data_i  in  64  write data, already lane-aligned by initiator
- w_mask_i  in  8  byte enables, already lane-aligned
- w_valid_o  out  1  write completed
- w_ready_i  in  1  initiator takes write completion
- r_valid_i  in  1  read request valid
- r_ready_o  out  1  read request accepted when high with r_valid_i
- r_addr_i  in  64  read byte address
- r_size_i  in  8  read size in bytes (1,2,4,8)
- data_read_o  out  64  read data, right-justified
- data_valid  out  1  read data valid
- data_ready  in  1  initiator takes read data
- err_o  out  1  one-cycle pulse, out-of-range access (see Configuration)

## Operation
- FSM states: IDLE, WAIT, WRESP, RRESP.
- IDLE:
  - w_ready_o=1. r_ready_o=~w_valid_i, so write wins a simultaneous request.
  - On handshake, capture address, data, mask and size, load the counter with LATENCY-1, and go to WAIT.
  - Record whether the request is a read or a write.
- WAIT:
  - Counter decrements each cycle. At zero, a write goes to WRESP and a read goes to RRESP.
  - A write commits to the array on the WAIT→WRESP edge.
  - A read samples the array on the WAIT→RRESP edge.
- WRESP: w_valid_o=1 until w_ready_i; on that edge go to IDLE.
- RRESP: data_valid=1 and data_read_o stable until data_ready; on that edge go to IDLE.
- Index = (addr−BASE)>>3, low log2(DEPTH) bits.
- Write: byte lane k of word ← w_data_i[8k+7:8k] where w_mask_i[k]=1.
- Read: word >> (8·addr[2:0]), then bytes at and above r_size_i are zeroed.
  - Sizes other than 1/2/4/8 are treated as 8.
  - Sign extension is the initiator's job.
- Requests arriving outside IDLE are not accepted; the readies are 0 there.

## Timing
- Reset values:
  - state IDLE.
  - w_valid_o, data_valid, err_o are 0; data_read_o is 0.
  - w_ready_o and r_ready_o are 0 during reset and in the first cycle after release (registered enable flag), then follow the IDLE rule.
- Accept on edge E0. The response is valid from edge E0+LATENCY. Earliest next accept is the edge after the response handshake.
- Response valid is held with stable data until the handshake. The responder never drops valid early.
- Reset mid-operation aborts the request: no array write, no response, back to IDLE. Array contents are not reset.
- Addresses that are not word-aligned are legal; only the word index and lane shift are used.

## Configuration
- MEM_RESP_BOUNDS_EN defined:
  - An address outside [BASE, BASE+8·DEPTH) pulses err_o on the accept cycle.
  - An out-of-range write still completes its handshake but does not modify the array.
  - An out-of-range read returns 64'hDEADBEEF_DEADBEEF, with no shift or size masking.
- Undefined: err_o tied 0, and the index silently wraps.

## Structure
- Package ysyx_22041207_mem_resp_pkg holds:
  - the state encoding (2 bits);
  - the OOR read pattern;
  - the size-to-byte-mask helper constant.
- Sub-module ysyx_22041207_mem_resp_array is the DEPTH×64 array with a byte-masked synchronous write port and a synchronous read port. The FSM, counter, shift/mask logic and handshakes stay in the top.

## Test plan
- Write, then read back:
  - Stimulus: write addr 0x8000_0008, data 0x1122334455667788, mask 0xFF, LATENCY=2.
  - Response: w_valid_o at accept+2.
  - Then a read of the same address with size 8 returns 0x1122334455667788.
- Byte lane write/read:
  - Stimulus: write addr 0x8000_0013, data 0xAB<<24, mask 0x08; then read 0x8000_0013 with size 1.
  - Response: data 0x00000000000000AB; other bytes of word 2 are unchanged.
- Simultaneous requests:
  - Stimulus: w_valid_i and r_valid_i high in the same cycle.
  - Response: write accepted, r_ready_o=0. The read is accepted only after the write response handshake and returns the new data.
- Backpressure:
  - Stimulus: hold data_ready=0 for 5 cycles.
  - Response: data_valid and data_read_o stay constant, w_ready_o/r_ready_o stay 0, and the FSM leaves only on the handshake.
- Reset in WAIT:
  - Stimulus: assert rst_n=0 one cycle after a write accept.
  - Response: all outputs go to their reset values and the word is unchanged on a later read.
- Out-of-range access (MEM_RESP_BOUNDS_EN):
  - Stimulus: read 0x7FFF_FFF8.
  - Response: err_o pulses and data 0xDEADBEEFDEADBEEF is returned.
  - Stimulus: write 0x8000_0000+8·DEPTH.
  - Response: completes, and array word 0 is unchanged.

Source files
------------

// File: rtl/ysyx_22041207_mem_resp_pkg.sv
// Shared definitions for the memory-stage responder: FSM state encoding,
// the out-of-range read pattern and the read-size byte-mask helper.
package ysyx_22041207_mem_resp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_RRESP = 2'd3;

  localparam logic [63:0] OOR_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

  localparam logic [63:0] SIZE_MASK_1 = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] SIZE_MASK_2 = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] SIZE_MASK_4 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] SIZE_MASK_8 = 64'hFFFF_FFFF_FFFF_FFFF;

  // Keep bytes below the requested size; unsupported sizes read a full word.
  function automatic logic [63:0] size_mask(input logic [7:0] size);
    logic [63:0] m;
    case (size)
      8'd1:    m = SIZE_MASK_1;
      8'd2:    m = SIZE_MASK_2;
      8'd4:    m = SIZE_MASK_4;
      default: m = SIZE_MASK_8;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22041207_mem_resp_array.sv
// DEPTH x 64-bit storage with a byte-masked synchronous write port and a
// synchronous read port. Only the read register is reset; contents are not.
module ysyx_22041207_mem_resp_array #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [63:0]              wdata_i,
  input  logic [7:0]               wmask_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [63:0]              rdata_o
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_q, rdata_d;

  // Byte-lane write into the selected word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (wmask_i[k]) mem[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Read register holds its value until the next read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem[raddr_i];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_22041207_mem_responder.sv
// Memory-stage responder: accepts one read or write at a time over a
// valid/ready bus, services it from an internal array after LATENCY cycles
// and returns a handshaked response.
// Optional feature: define MEM_RESP_BOUNDS_EN for address range checking.
module ysyx_22041207_mem_responder
  import ysyx_22041207_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic [63:0] w_addr_i,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_mask_i,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  input  logic [63:0] r_addr_i,
  input  logic [7:0]  r_size_i,
  output logic [63:0] data_read_o,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [7:0]    size_q, size_d;
  logic          is_wr_q, is_wr_d;
  logic          en_q;

  logic          w_hs, r_hs, accept, wait_done;
  logic          arr_we, arr_re;
  logic [63:0]   req_addr, offset, rword, shifted;
  logic [AW-1:0] idx;
  logic          unused_offset_bits;

  // Request-side handshakes; write takes priority over a simultaneous read.
  always_comb begin
    w_ready_o = en_q && (state_q == ST_IDLE);
    r_ready_o = en_q && (state_q == ST_IDLE) && !w_valid_i;
    w_hs      = w_valid_i && w_ready_o;
    r_hs      = r_valid_i && r_ready_o;
    accept    = w_hs || r_hs;
    req_addr  = w_hs ? w_addr_i : r_addr_i;
    wait_done = (state_q == ST_WAIT) && (cnt_q == '0);
  end

  // FSM next state, latency counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    is_wr_d = is_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = req_addr;
          wdata_d = w_data_i;
          wmask_d = w_mask_i;
          size_d  = r_size_i;
          is_wr_d = w_hs;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = is_wr_q ? ST_WRESP : ST_RRESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WRESP: if (w_ready_i)  state_d = ST_IDLE;
      ST_RRESP: if (data_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      size_q  <= '0;
      is_wr_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      is_wr_q <= is_wr_d;
      en_q    <= 1'b1;
    end
  end

  // Word index from the captured byte address.
  always_comb begin
    offset             = addr_q - BASE;
    idx                = offset[AW+2:3];
    unused_offset_bits = ^{offset[63:AW+3], offset[2:0]};
  end

`ifdef MEM_RESP_BOUNDS_EN
  logic oor_q, oor_d, err_q, err_d;

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < (64'(DEPTH) * 64'd8));
  endfunction

  // Range flag follows the accepted request; err pulses for one cycle.
  always_comb begin
    oor_d = oor_q;
    err_d = 1'b0;
    if (accept) begin
      oor_d = !in_range(req_addr);
      err_d = !in_range(req_addr);
    end
  end

  // Range-check registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
      err_q <= err_d;
    end
  end

  // Array strobes on the WAIT exit edge; out-of-range writes are dropped.
  always_comb begin
    arr_we = wait_done && is_wr_q && !oor_q;
    arr_re = wait_done && !is_wr_q;
    err_o  = err_q;
  end
`else
  // Array strobes on the WAIT exit edge; index wraps silently.
  always_comb begin
    arr_we = wait_done && is_wr_q;
    arr_re = wait_done && !is_wr_q;
    err_o  = 1'b0;
  end
`endif

  ysyx_22041207_mem_resp_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (arr_we),
    .waddr_i (idx),
    .wdata_i (wdata_q),
    .wmask_i (wmask_q),
    .re_i    (arr_re),
    .raddr_i (idx),
    .rdata_o (rword)
  );

  // Response outputs; read data is lane-shifted and size-masked from the
  // registered array word, so it stays stable for the whole RRESP state.
  always_comb begin
    w_valid_o   = (state_q == ST_WRESP);
    data_valid  = (state_q == ST_RRESP);
    shifted     = rword >> {addr_q[2:0], 3'b000};
    data_read_o = shifted & size_mask(size_q);
`ifdef MEM_RESP_BOUNDS_EN
    if (oor_q) data_read_o = OOR_RDATA;
`endif
  end

endmodule
